// File: rtl/chunked_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chunked_addsub                                                |
// | Purpose  : Multi-cycle N-bit adder/subtractor. Each RUN cycle pushes K   |
// |            bits through a K-slice full-adder chain. A registered carry   |
// |            links one chunk to the next, so the critical path is K bits   |
// |            long, not N. Operands enter and results leave through         |
// |            valid/ready handshakes, with one operation in flight.         |
// | Config   : `define CHUNKED_ADDSUB_OVF_EN to build signed-overflow         |
// |            tracking. Without it, ovf is tied to 0.                       |
// | Ports    : clk, rst_n    - clock, synchronous active-low reset           |
// |            in_valid/in_ready   - operand handshake (a, b, sub, cin)      |
// |            out_valid/out_ready - result handshake (sum, cout, ovf)       |
// |            sub=0: sum = a + b + cin                                      |
// |            sub=1: sum = a - b - cin; cout=1 means no borrow              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module chunked_addsub #(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int c_CHUNKS = N / K;
   localparam int c_IDX_W  = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_CHUNKS - 1);

   if (K < 1 || K > N || (N % K) != 0) begin : g_bad_param
      $error("chunked_addsub: K must lie in 1..N and divide N exactly");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N-1:0]         r_a;
   logic [N-1:0]         r_b;        // already inverted for subtract
   logic                 r_carry;
   logic [c_IDX_W-1:0]   r_idx;
   logic [N-1:0]         r_sum;

   logic [K-1:0]         w_a_chunk;
   logic [K-1:0]         w_b_chunk;
   logic [K-1:0]         w_s;
   logic [K:0]           w_c;        // w_c[i] = carry into slice i
   logic                 w_last;

   assign w_last = (r_idx == c_LAST);

   // Select the operand slice for the current chunk.
   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int j = 0; j < c_CHUNKS; j++) begin
         if (r_idx == c_IDX_W'(j)) begin
            w_a_chunk = r_a[j*K +: K];
            w_b_chunk = r_b[j*K +: K];
         end
      end
   end

   // K-bit ripple chain of full-adder slices.
   assign w_c[0] = r_carry;
   for (genvar i = 0; i < K; i++) begin : g_slice
      assign w_s[i]   = w_a_chunk[i] ^ w_b_chunk[i] ^ w_c[i];
      assign w_c[i+1] = (w_a_chunk[i] & w_b_chunk[i]) |
                        (w_c[i] & (w_a_chunk[i] ^ w_b_chunk[i]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  // Subtract is a + ~b + !cin, so invert B and the borrow up front.
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub ? ~cin : cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               for (int j = 0; j < c_CHUNKS; j++) begin
                  if (r_idx == c_IDX_W'(j)) begin
                     r_sum[j*K +: K] <= w_s;
                  end
               end
               r_carry <= w_c[K];
               r_idx   <= w_last ? '0 : r_idx + c_IDX_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

`ifdef CHUNKED_ADDSUB_OVF_EN
   logic r_ovf;

   // On the last chunk, slice K-1 is bit N-1. Overflow is the carry into
   // the MSB XOR the carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN && w_last) begin
         r_ovf <= w_c[K-1] ^ w_c[K];
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign sum  = r_sum;
   // The carry register holds the final carry out of bit N-1 in DONE.
   assign cout = r_carry;

endmodule
`default_nettype wire
